id_ex_stage: RTL and testbench

- ID/EX pipeline stage that directly feeds the EX-stage ALU.
- Registers decoded operands and control, then applies EX/MEM and MEM/WB forwarding.
- Builds the ALU operand pair (src1, src2) and carries the 9-bit ALU operation code.
- Detects load-use hazards, stalls ID/IF, and inserts bubbles. Accepts flush from branch resolution and hold from downstream.

---
 rtl/id_ex_stage_pkg.sv | 33 +++
 rtl/id_ex_stage_fwd_mux.sv | 45 ++++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: operand widths and the 9-bit ALU operation codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 16;

  typedef logic [8:0] alu_op_t;

  // One-hot ALU operation codes; 0 means "no operation" and is what a bubble carries.
  localparam alu_op_t ALUOp_NOP = 9'h000;
  localparam alu_op_t ALUOp_ADD = 9'h001;
  localparam alu_op_t ALUOp_SUB = 9'h002;
  localparam alu_op_t ALUOp_AND = 9'h004;
  localparam alu_op_t ALUOp_OR  = 9'h008;
  localparam alu_op_t ALUOp_XOR = 9'h010;
  localparam alu_op_t ALUOp_NOR = 9'h020;
  localparam alu_op_t ALUOp_SLT = 9'h040;
  localparam alu_op_t ALUOp_SLL = 9'h080;
  localparam alu_op_t ALUOp_LUI = 9'h100;

  // Control carried alongside the operands into EX.
  typedef struct packed {
    alu_op_t alu_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    use_imm;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding select for one ALU operand: EX/MEM over MEM/WB over register-file data.
// Latency: combinational.
// Backpressure: none; pure datapath.
//
// Ports:
//   addr           source register number of the operand (register 0 never forwards)
//   raw            registered register-file read data
//   exmem_*        EX/MEM forwarding source (write enable, destination, data)
//   memwb_*        MEM/WB forwarding source (write enable, destination, data)
//   data           selected operand value
module id_ex_stage_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] raw,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] data
);

  logic addr_nz;
  logic exmem_hit;
  logic memwb_hit;

  // Register 0 is hardwired to zero, so a "write" to it must never be forwarded.
  assign addr_nz   = (addr != '0);
  assign exmem_hit = addr_nz && exmem_reg_write && (exmem_rd == addr);
  assign memwb_hit = addr_nz && memwb_reg_write && (memwb_rd == addr);

  // The younger result (EX/MEM) wins when both stages target the same register.
  always_comb begin
    data = raw;
    if (exmem_hit) begin
      data = exmem_result;
    end else if (memwb_hit) begin
      data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decode, forwards operands, detects load-use.
// Latency: one cycle ID to EX; forwarding muxes are combinational on the registered fields.
// Backpressure: ex_hold freezes all state; load_use_stall (combinational) holds ID/IF and bubbles EX.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   id_*                   decoded instruction from ID (operands, addresses, immediate, control)
//   flush                  kill the instruction entering EX (redirect from branch resolution)
//   ex_hold                downstream stall; nothing in this stage changes
//   exmem_*, memwb_*       forwarding sources from later stages
//   ex_*                   live EX-stage instruction: operands, ALU op, store data, destination, control
//   load_use_stall         ID/IF must hold this cycle
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [8:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [15:0]       id_imm,
  input  logic              id_use_imm,
  input  logic              id_zero_ext,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_src1,
  output logic [DATA_W-1:0] ex_src2,
  output logic [8:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_stall
);

  // Everything held in the pipeline register; all-zero is both the reset and the bubble value.
  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } ex_reg_t;

  ex_reg_t           ex_q;
  ex_reg_t           ex_load;
  logic              bubble;
  logic              rs_dep;
  logic              rt_dep;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // ---------------------------------------------------------------------------
  // Load-use hazard: the load in EX produces its value only after MEM, so a
  // dependent instruction in ID cannot be satisfied by forwarding next cycle.
  // Suppressed under hold (nothing moves) and flush (ID instruction is dead).
  // ---------------------------------------------------------------------------
  assign rs_dep = id_uses_rs && (id_rs_addr == ex_q.rd);
  assign rt_dep = id_uses_rt && (id_rt_addr == ex_q.rd);

  assign load_use_stall = !ex_hold && !flush && id_valid && ex_q.valid &&
                          ex_q.ctrl.mem_read && (ex_q.rd != '0) && (rs_dep || rt_dep);

  assign bubble = flush || load_use_stall;

  // ---------------------------------------------------------------------------
  // Next value when loading from ID. Control is qualified by id_valid so an
  // invalid slot can never write the register file or touch memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_load                = '0;
    ex_load.valid          = id_valid;
    ex_load.ctrl.alu_op    = id_valid ? id_alu_op : ALUOp_NOP;
    ex_load.ctrl.reg_write = id_valid && id_reg_write;
    ex_load.ctrl.mem_read  = id_valid && id_mem_read;
    ex_load.ctrl.mem_write = id_valid && id_mem_write;
    ex_load.ctrl.use_imm   = id_use_imm;
    ex_load.rs_addr        = id_rs_addr;
    ex_load.rt_addr        = id_rt_addr;
    ex_load.rd             = id_rd_addr;
    ex_load.rs_data        = id_rs_data;
    ex_load.rt_data        = id_rt_data;
    // Extend once at capture so the EX path is a plain mux.
    if (id_zero_ext) begin
      ex_load.imm = {{(DATA_W-16){1'b0}}, id_imm};
    end else begin
      ex_load.imm = {{(DATA_W-16){id_imm[15]}}, id_imm};
    end
  end

  // Priority: reset, then hold (keep everything), then bubble, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (!ex_hold) begin
      if (bubble) begin
        ex_q <= '0;
      end else begin
        ex_q <= ex_load;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand forwarding, one mux per source register.
  // ---------------------------------------------------------------------------
  id_ex_stage_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .addr            (ex_q.rs_addr),
    .raw             (ex_q.rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (rs_fwd)
  );

  id_ex_stage_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .addr            (ex_q.rt_addr),
    .raw             (ex_q.rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (rt_fwd)
  );

  // ---------------------------------------------------------------------------
  // Outputs. Shifts and LUI take src2 from the immediate (decoder sets use_imm),
  // while stores always need the forwarded rt regardless of use_imm.
  // ---------------------------------------------------------------------------
  assign ex_valid      = ex_q.valid;
  assign ex_src1       = rs_fwd;
  assign ex_src2       = ex_q.ctrl.use_imm ? ex_q.imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign ex_alu_op     = ex_q.ctrl.alu_op;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.valid && ex_q.ctrl.reg_write;
  assign ex_mem_read   = ex_q.valid && ex_q.ctrl.mem_read;
  assign ex_mem_write  = ex_q.valid && ex_q.ctrl.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, immediate extension, forwarding, load-use, flush, hold.
// Inputs change just after a rising edge; outputs are checked 1 time unit after inputs settle.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [8:0]  id_alu_op;
  logic [31:0] id_rs_data, id_rt_data;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_uses_rs, id_uses_rt;
  logic [15:0] id_imm;
  logic        id_use_imm, id_zero_ext;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_hold;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic [31:0] ex_src1, ex_src2, ex_store_data;
  logic [8:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk (clk), .rst (rst),
    .id_valid (id_valid), .id_alu_op (id_alu_op),
    .id_rs_data (id_rs_data), .id_rt_data (id_rt_data),
    .id_rs_addr (id_rs_addr), .id_rt_addr (id_rt_addr), .id_rd_addr (id_rd_addr),
    .id_uses_rs (id_uses_rs), .id_uses_rt (id_uses_rt),
    .id_imm (id_imm), .id_use_imm (id_use_imm), .id_zero_ext (id_zero_ext),
    .id_reg_write (id_reg_write), .id_mem_read (id_mem_read), .id_mem_write (id_mem_write),
    .flush (flush), .ex_hold (ex_hold),
    .exmem_reg_write (exmem_reg_write), .exmem_rd (exmem_rd), .exmem_result (exmem_result),
    .memwb_reg_write (memwb_reg_write), .memwb_rd (memwb_rd), .memwb_result (memwb_result),
    .ex_valid (ex_valid), .ex_src1 (ex_src1), .ex_src2 (ex_src2),
    .ex_alu_op (ex_alu_op), .ex_store_data (ex_store_data), .ex_rd (ex_rd),
    .ex_reg_write (ex_reg_write), .ex_mem_read (ex_mem_read), .ex_mem_write (ex_mem_write),
    .load_use_stall (load_use_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_alu_op = ALUOp_NOP;
    id_rs_data = 0; id_rt_data = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    id_imm = 0; id_use_imm = 0; id_zero_ext = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic fwd_clear();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  // Present a load "lw r<rd>, 0(r1)" from ID.
  task automatic id_load(input logic [4:0] rd);
    id_clear();
    id_valid = 1; id_alu_op = ALUOp_ADD; id_rs_addr = 5'd1; id_uses_rs = 1;
    id_use_imm = 1; id_rd_addr = rd; id_reg_write = 1; id_mem_read = 1;
  endtask

  // Present "add r4, r1, r<rt>" from ID.
  task automatic id_add_rt(input logic [4:0] rt, input logic uses_rt);
    id_clear();
    id_valid = 1; id_alu_op = ALUOp_ADD; id_rs_addr = 5'd1; id_uses_rs = 1;
    id_rt_addr = rt; id_uses_rt = uses_rt; id_rd_addr = 5'd4; id_reg_write = 1;
    id_rs_data = 32'h0000_0100; id_rt_data = 32'h0000_0200;
  endtask

  initial begin
    rst = 1; flush = 0; ex_hold = 0;
    id_clear(); fwd_clear();

    // Reset held two cycles with a valid load on ID.
    id_load(5'd3); id_imm = 16'h1234;
    step(); step();
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_regwr", {31'b0, ex_reg_write}, 32'd0);
    chk("rst_memrd", {31'b0, ex_mem_read}, 32'd0);
    chk("rst_memwr", {31'b0, ex_mem_write}, 32'd0);
    chk("rst_aluop", {23'b0, ex_alu_op}, 32'd0);
    chk("rst_rd", {27'b0, ex_rd}, 32'd0);
    chk("rst_src1", ex_src1, 32'd0);
    chk("rst_src2", ex_src2, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_stall", {31'b0, load_use_stall}, 32'd0);

    // Sign-extended immediate.
    rst = 0;
    id_clear();
    id_valid = 1; id_alu_op = ALUOp_ADD; id_rs_addr = 5'd1; id_rs_data = 32'h10;
    id_uses_rs = 1; id_use_imm = 1; id_imm = 16'h8000; id_rd_addr = 5'd2; id_reg_write = 1;
    step();
    chk("sext_valid", {31'b0, ex_valid}, 32'd1);
    chk("sext_src2", ex_src2, 32'hFFFF_8000);
    chk("sext_src1", ex_src1, 32'h10);
    chk("sext_rd", {27'b0, ex_rd}, 32'd2);
    chk("sext_regwr", {31'b0, ex_reg_write}, 32'd1);
    chk("sext_aluop", {23'b0, ex_alu_op}, {23'b0, ALUOp_ADD});

    // Zero-extended immediate.
    id_zero_ext = 1;
    step();
    chk("zext_src2", ex_src2, 32'h0000_8000);

    // Forwarding priority on rs, MEM/WB on rt.
    id_clear();
    id_valid = 1; id_alu_op = ALUOp_OR; id_rs_addr = 5'd5; id_rs_data = 32'hAA;
    id_rt_addr = 5'd6; id_rt_data = 32'h66; id_uses_rs = 1; id_uses_rt = 1; id_rd_addr = 5'd7;
    step();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
    #1;
    chk("fwd_exmem_pri", ex_src1, 32'h11);
    chk("fwd_rt_nohit", ex_src2, 32'h66);
    exmem_reg_write = 0;
    #1;
    chk("fwd_memwb", ex_src1, 32'h22);
    memwb_reg_write = 0;
    #1;
    chk("fwd_raw", ex_src1, 32'hAA);
    memwb_reg_write = 1; memwb_rd = 5'd6;
    #1;
    chk("fwd_rt_src2", ex_src2, 32'h22);
    chk("fwd_rt_store", ex_store_data, 32'h22);
    fwd_clear();

    // Register 0 never forwards.
    id_clear();
    id_valid = 1; id_alu_op = ALUOp_ADD; id_uses_rs = 1; id_rd_addr = 5'd8;
    step();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
    #1;
    chk("r0_nofwd", ex_src1, 32'd0);
    fwd_clear();

    // Load-use on rt: stall, bubble, then the add enters.
    id_load(5'd3);
    step();
    chk("lu_load_memrd", {31'b0, ex_mem_read}, 32'd1);
    id_add_rt(5'd3, 1'b1);
    #1;
    chk("lu_stall", {31'b0, load_use_stall}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu_bubble_regwr", {31'b0, ex_reg_write}, 32'd0);
    chk("lu_bubble_aluop", {23'b0, ex_alu_op}, 32'd0);
    chk("lu_stall_drop", {31'b0, load_use_stall}, 32'd0);
    step();
    chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_add_rd", {27'b0, ex_rd}, 32'd4);
    chk("lu_add_src2", ex_src2, 32'h200);

    // Same dependency pattern but rt not read: no stall.
    id_load(5'd3);
    step();
    id_add_rt(5'd3, 1'b0);
    #1;
    chk("nolu_stall", {31'b0, load_use_stall}, 32'd0);
    step();
    chk("nolu_valid", {31'b0, ex_valid}, 32'd1);
    chk("nolu_rd", {27'b0, ex_rd}, 32'd4);

    // Flush together with a load-use: flush wins, bubble inserted.
    id_load(5'd3);
    step();
    id_add_rt(5'd3, 1'b1);
    flush = 1;
    #1;
    chk("flush_stall", {31'b0, load_use_stall}, 32'd0);
    step();
    flush = 0;
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_regwr", {31'b0, ex_reg_write}, 32'd0);

    // Hold for 3 cycles while ID changes (and flush is raised once).
    id_clear();
    id_valid = 1; id_alu_op = ALUOp_SUB; id_rs_addr = 5'd7; id_rs_data = 32'h77;
    id_rt_addr = 5'd8; id_rt_data = 32'h88; id_uses_rs = 1; id_uses_rt = 1;
    id_rd_addr = 5'd9; id_reg_write = 1; id_mem_write = 1;
    step();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      id_load(5'd10 + 5'(i));
      id_rs_data = 32'h1000 + 32'(i);
      flush = (i == 1);
      step();
      chk("hold_valid", {31'b0, ex_valid}, 32'd1);
      chk("hold_src1", ex_src1, 32'h77);
      chk("hold_src2", ex_src2, 32'h88);
      chk("hold_rd", {27'b0, ex_rd}, 32'd9);
      chk("hold_aluop", {23'b0, ex_alu_op}, {23'b0, ALUOp_SUB});
      chk("hold_memwr", {31'b0, ex_mem_write}, 32'd1);
    end
    ex_hold = 0; flush = 0;
    step();
    chk("unhold_rd", {27'b0, ex_rd}, 32'd12);
    chk("unhold_memrd", {31'b0, ex_mem_read}, 32'd1);

    // Reset in the middle of a stall.
    id_add_rt(5'd12, 1'b1);
    #1;
    chk("rststall_pre", {31'b0, load_use_stall}, 32'd1);
    rst = 1;
    step();
    chk("rststall_valid", {31'b0, ex_valid}, 32'd0);
    chk("rststall_stall", {31'b0, load_use_stall}, 32'd0);
    chk("rststall_memrd", {31'b0, ex_mem_read}, 32'd0);
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
